// File: rtl/zmod_adc_spi_responder_if.sv
// AD9648-style 3-wire SPI config port, split into separate SDIO in/out/oe
// wires so that one responder can sit on an ordinary logic net.
//   i_sck      SPI clock from master, idles high
//   i_cs       chip select, active-low
//   i_sdio     SDIO master -> slave
//   o_sdio     SDIO slave drive value during the read data phase
//   o_sdio_oe  1 = slave drives SDIO
interface zmod_adc_spi_responder_if;
   logic i_sck;
   logic i_cs;
   logic i_sdio;
   logic o_sdio;
   logic o_sdio_oe;

   modport master (output i_sck, output i_cs, output i_sdio,
                   input  o_sdio, input o_sdio_oe);
   modport slave  (input  i_sck, input  i_cs, input  i_sdio,
                   output o_sdio, output o_sdio_oe);
endinterface

// File: rtl/zmod_adc_spi_responder.sv
// SPI responder that emulates the AD9648 register subset used by the ZMOD
// ADC bring-up. Frames are RW | W[1:0] | A[12:0] | DATA[7:0]..., MSB first,
// with the address decrementing after each data byte.
// sck/cs/sdio are oversampled in clk. That is why clk must run at least
// 3 cycles per sck half-period.
// Ports:
//   clk, rstn            system clock, synchronous active-low reset
//   spi                  slave modport of the SPI pin bundle
//   o8_pwrmode_a/_b      reg 0x08, channel A / B copy
//   o8_testmode_a/_b     reg 0x0D, channel A / B copy
//   o8_omode_a/_b        reg 0x14, channel A / B copy
//   o2_chsel             reg 0x05 bits[1:0], channel write/read select
//   o_frame_done         1-clk pulse, frame ended cleanly on a byte boundary
//   o_frame_err          1-clk pulse, frame cut short mid-header or mid-byte
//   o_bad_addr           1-clk pulse per data byte aimed at an unmapped reg
//
// state     | meaning
// S_IDLE    | cs high, waiting for cs low
// S_HEADER  | shifting in the 16 instruction bits
// S_DATA    | transferring data bytes (write: shift in, read: shift out)
// S_WAIT_CS | all announced bytes done, sck ignored until cs rises
module zmod_adc_spi_responder #(
   parameter logic [7:0] P_CHIP_ID     = 8'h88,
   parameter logic [7:0] P_CHSEL_RST   = 8'h03,
   parameter logic [7:0] P_OMODE_RST   = 8'h01,
   parameter int         P_SYNC_STAGES = 2
) (
   input  logic                           clk,
   input  logic                           rstn,
   zmod_adc_spi_responder_if.slave        spi,
   output logic [7:0]                     o8_pwrmode_a,
   output logic [7:0]                     o8_pwrmode_b,
   output logic [7:0]                     o8_testmode_a,
   output logic [7:0]                     o8_testmode_b,
   output logic [7:0]                     o8_omode_a,
   output logic [7:0]                     o8_omode_b,
   output logic [1:0]                     o2_chsel,
   output logic                           o_frame_done,
   output logic                           o_frame_err,
   output logic                           o_bad_addr
);

   localparam logic [12:0] A_CHIP_ID  = 13'h001;
   localparam logic [12:0] A_CHSEL    = 13'h005;
   localparam logic [12:0] A_PWRMODE  = 13'h008;
   localparam logic [12:0] A_TESTMODE = 13'h00D;
   localparam logic [12:0] A_OMODE    = 13'h014;

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_WAIT_CS} state_t;

   state_t state, state_n;

   logic [P_SYNC_STAGES-1:0] sck_sync, cs_sync, sdio_sync;
   logic sck_s, cs_s, sdio_s, sck_d;
   logic sck_rise, sck_fall, abort;

   logic [3:0]  bit_cnt;
   logic [14:0] shift_in;
   logic [7:0]  shift_out;
   logic [12:0] addr;
   logic [2:0]  nbytes;
   logic        rw;
   logic        got_byte;
   logic        sdio_q, sdio_oe_q;

   logic        wr_pend;
   logic [12:0] wr_addr;
   logic [7:0]  wr_data;

   logic        hdr_last, byte_last, done_p, err_p;
   logic [15:0] hdr_word;
   logic [7:0]  byte_word;
   logic [12:0] addr_dec, rd_addr;
   logic [7:0]  rd_byte;
   logic        addr_ok;

   // ---------------------------------------------------------------- sync
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sck_sync  <= '1;
         cs_sync   <= '1;
         sdio_sync <= '0;
         sck_d     <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[P_SYNC_STAGES-2:0],  spi.i_sck};
         cs_sync   <= {cs_sync[P_SYNC_STAGES-2:0],   spi.i_cs};
         sdio_sync <= {sdio_sync[P_SYNC_STAGES-2:0], spi.i_sdio};
         sck_d     <= sck_s;
      end
   end

   assign sck_s    = sck_sync[P_SYNC_STAGES-1];
   assign cs_s     = cs_sync[P_SYNC_STAGES-1];
   assign sdio_s   = sdio_sync[P_SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   // cs high beats a coincident sck rise: that bit is simply dropped
   assign abort    = cs_s && (state != S_IDLE);

   assign hdr_word  = {shift_in, sdio_s};
   assign byte_word = {shift_in[6:0], sdio_s};
   assign addr_dec  = addr - 13'd1;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      hdr_last  = 1'b0;
      byte_last = 1'b0;
      done_p    = 1'b0;
      err_p     = 1'b0;
      case (state)
         S_IDLE: begin
            if (!cs_s) state_n = S_HEADER;
         end
         S_HEADER: begin
            if (abort) begin
               state_n = S_IDLE;
               err_p   = 1'b1;
            end else if (sck_rise && bit_cnt == 4'd15) begin
               hdr_last = 1'b1;
               state_n  = S_DATA;
            end
         end
         S_DATA: begin
            if (abort) begin
               state_n = S_IDLE;
               done_p  = (bit_cnt == 4'd0) && got_byte;
               err_p   = !((bit_cnt == 4'd0) && got_byte);
            end else if (sck_rise && bit_cnt == 4'd7) begin
               byte_last = 1'b1;
               if (nbytes == 3'd1) state_n = S_WAIT_CS;
            end
         end
         S_WAIT_CS: begin
            if (abort) begin
               state_n = S_IDLE;
               done_p  = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------ read mux
   // At the end of the header the new address is still on the shift path;
   // at the end of a read byte we preload the next (decremented) address.
   assign rd_addr = hdr_last ? hdr_word[12:0] : addr_dec;

   always_comb begin
      rd_byte = 8'h00;
      case (rd_addr)
         A_CHIP_ID:  rd_byte = P_CHIP_ID;
         A_CHSEL:    rd_byte = {6'b0, o2_chsel};
         A_PWRMODE:  rd_byte = o2_chsel[0] ? o8_pwrmode_a  :
                               o2_chsel[1] ? o8_pwrmode_b  : 8'h00;
         A_TESTMODE: rd_byte = o2_chsel[0] ? o8_testmode_a :
                               o2_chsel[1] ? o8_testmode_b : 8'h00;
         A_OMODE:    rd_byte = o2_chsel[0] ? o8_omode_a    :
                               o2_chsel[1] ? o8_omode_b    : 8'h00;
         default:    rd_byte = 8'h00;
      endcase
   end

   assign addr_ok = (addr == A_CHIP_ID) || (addr == A_CHSEL) || (addr == A_PWRMODE) ||
                    (addr == A_TESTMODE) || (addr == A_OMODE);

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk) begin
      if (!rstn) begin
         bit_cnt      <= '0;
         shift_in     <= '0;
         shift_out    <= '0;
         addr         <= '0;
         nbytes       <= '0;
         rw           <= 1'b0;
         got_byte     <= 1'b0;
         sdio_q       <= 1'b0;
         sdio_oe_q    <= 1'b0;
         wr_pend      <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
         o_bad_addr   <= 1'b0;
      end else begin
         o_frame_done <= done_p;
         o_frame_err  <= err_p;
         o_bad_addr   <= 1'b0;
         wr_pend      <= 1'b0;
         if (abort) begin
            sdio_oe_q <= 1'b0;
            sdio_q    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  bit_cnt   <= '0;
                  got_byte  <= 1'b0;
                  sdio_oe_q <= 1'b0;
                  sdio_q    <= 1'b0;
               end
               S_HEADER: begin
                  if (sck_rise) begin
                     shift_in <= {shift_in[13:0], sdio_s};
                     bit_cnt  <= bit_cnt + 4'd1;
                     if (hdr_last) begin
                        rw        <= hdr_word[15];
                        nbytes    <= {1'b0, hdr_word[14:13]} + 3'd1;
                        addr      <= hdr_word[12:0];
                        bit_cnt   <= '0;
                        shift_out <= rd_byte;
                     end
                  end
               end
               S_DATA: begin
                  if (sck_rise) begin
                     shift_in <= {shift_in[13:0], sdio_s};
                     bit_cnt  <= bit_cnt + 4'd1;
                     if (byte_last) begin
                        bit_cnt    <= '0;
                        got_byte   <= 1'b1;
                        addr       <= addr_dec;
                        nbytes     <= nbytes - 3'd1;
                        o_bad_addr <= !addr_ok;
                        if (rw) begin
                           shift_out <= rd_byte;
                        end else begin
                           wr_pend <= 1'b1;
                           wr_addr <= addr;
                           wr_data <= byte_word;
                        end
                        if (nbytes == 3'd1) begin
                           sdio_oe_q <= 1'b0;
                           sdio_q    <= 1'b0;
                        end
                     end
                  end else if (sck_fall && rw) begin
                     sdio_q    <= shift_out[7];
                     shift_out <= {shift_out[6:0], 1'b0};
                     sdio_oe_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign spi.o_sdio    = sdio_q;
   assign spi.o_sdio_oe = sdio_oe_q;

   // ------------------------------------------------------------ reg file
   // Per-channel registers fan out by chsel; chsel 0 makes the write a no-op.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         o8_pwrmode_a  <= 8'h00;
         o8_pwrmode_b  <= 8'h00;
         o8_testmode_a <= 8'h00;
         o8_testmode_b <= 8'h00;
         o8_omode_a    <= P_OMODE_RST;
         o8_omode_b    <= P_OMODE_RST;
         o2_chsel      <= P_CHSEL_RST[1:0];
      end else if (wr_pend) begin
         case (wr_addr)
            A_CHSEL: o2_chsel <= wr_data[1:0];
            A_PWRMODE: begin
               if (o2_chsel[0]) o8_pwrmode_a <= wr_data;
               if (o2_chsel[1]) o8_pwrmode_b <= wr_data;
            end
            A_TESTMODE: begin
               if (o2_chsel[0]) o8_testmode_a <= wr_data;
               if (o2_chsel[1]) o8_testmode_b <= wr_data;
            end
            A_OMODE: begin
               if (o2_chsel[0]) o8_omode_a <= wr_data;
               if (o2_chsel[1]) o8_omode_b <= wr_data;
            end
            default: ;
         endcase
      end
   end

endmodule
